// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and entry type for the register-file write-port arbiter.
// The MDU result buffer stores entries of this type.
package wb_port_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle around the write-port arbiter: MEM/WB inputs, MDU handshake,
// register-file write port, stall and ID-stage pending-write queries.
interface wb_port_arbiter_if import wb_port_arbiter_pkg::*; ();
  logic              wb_regwrite_i;
  logic              wb_memtoreg_i;
  logic [DATA_W-1:0] wb_alu_i;
  logic [DATA_W-1:0] wb_mem_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic              mdu_valid_i;
  logic              mdu_ready_o;
  logic [ADDR_W-1:0] mdu_addr_i;
  logic [DATA_W-1:0] mdu_data_i;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_data_o;
  logic              stall_o;
  logic [ADDR_W-1:0] q_rs_i;
  logic [ADDR_W-1:0] q_rt_i;
  logic [ADDR_W-1:0] q_rd_i;
  logic              pending_o;

  modport slave (
    input  wb_regwrite_i, wb_memtoreg_i, wb_alu_i, wb_mem_i, wb_addr_i,
    input  mdu_valid_i, mdu_addr_i, mdu_data_i, q_rs_i, q_rt_i, q_rd_i,
    output mdu_ready_o, rf_we_o, rf_addr_o, rf_data_o, stall_o, pending_o
  );

  modport master (
    output wb_regwrite_i, wb_memtoreg_i, wb_alu_i, wb_mem_i, wb_addr_i,
    output mdu_valid_i, mdu_addr_i, mdu_data_i, q_rs_i, q_rt_i, q_rd_i,
    input  mdu_ready_o, rf_we_o, rf_addr_o, rf_data_o, stall_o, pending_o
  );
endinterface

// File: rtl/wb_port_arbiter_result_fifo.sv
// Small sync FIFO for MDU results with per-entry valid bits and a combined
// match of three query addresses against the valid stored entries.
module wb_result_fifo import wb_port_arbiter_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  wb_entry_t                    push_entry_i,
  input  logic                         pop_i,
  output wb_entry_t                    head_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH):0]       count_o,
  input  logic [ADDR_W-1:0]            q_rs_i,
  input  logic [ADDR_W-1:0]            q_rt_i,
  input  logic [ADDR_W-1:0]            q_rd_i,
  output logic                         match_o
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
    if (push_i) begin
      mem_d[wr_ptr_q] = push_entry_i;
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
  end

  // Payload is not reset; only valid bits and pointers carry meaning after reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] &&
          ((q_rs_i != REG_ZERO && mem_q[i].addr == q_rs_i) ||
           (q_rt_i != REG_ZERO && mem_q[i].addr == q_rt_i) ||
           (q_rd_i != REG_ZERO && mem_q[i].addr == q_rd_i)))
        match_o = 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB has priority, MDU results are
// buffered and drained on free slots, with a forced one-cycle stall on starvation.
module wb_port_arbiter import wb_port_arbiter_pkg::*; #(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_port_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  wb_entry_t         head, push_entry;
  logic              fifo_empty, fifo_full, fifo_match;
  logic [CNT_W-1:0]  fifo_count, occ_d;
  logic              pipe_req, push, pop, we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, pipe_data;
  logic [SW-1:0]     starve_q, starve_d;
  logic              stall_q, stall_d;
  logic              ready;

  assign ready      = !fifo_full;
  assign push_entry = '{addr: bus.mdu_addr_i, data: bus.mdu_data_i};

  always_comb begin
    pipe_req  = bus.wb_regwrite_i && (bus.wb_addr_i != REG_ZERO);
    pipe_data = bus.wb_memtoreg_i ? bus.wb_mem_i : bus.wb_alu_i;
    we        = 1'b0;
    pop       = 1'b0;
    wr_addr   = REG_ZERO;
    wr_data   = '0;
    starve_d  = starve_q;
    // During a forced stall the frozen pipeline replays, so the buffer owns the port.
    if (stall_q && !fifo_empty) begin
      we       = 1'b1;
      pop      = 1'b1;
      wr_addr  = head.addr;
      wr_data  = head.data;
      starve_d = '0;
    end else if (pipe_req) begin
      we      = 1'b1;
      wr_addr = bus.wb_addr_i;
      wr_data = pipe_data;
      if (!fifo_empty && starve_q != SW'(STARVE_MAX))
        starve_d = starve_q + SW'(1);
    end else if (!fifo_empty) begin
      we       = 1'b1;
      pop      = 1'b1;
      wr_addr  = head.addr;
      wr_data  = head.data;
      starve_d = '0;
    end
    // Writes to r0 are consumed by the handshake but never stored.
    push    = bus.mdu_valid_i && ready && (bus.mdu_addr_i != REG_ZERO);
    occ_d   = fifo_count + CNT_W'(push) - CNT_W'(pop);
    stall_d = (starve_d == SW'(STARVE_MAX)) && (occ_d != '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .count_o      (fifo_count),
    .q_rs_i       (bus.q_rs_i),
    .q_rt_i       (bus.q_rt_i),
    .q_rd_i       (bus.q_rd_i),
    .match_o      (fifo_match)
  );

  // Combinational outputs are gated so they drop as soon as reset asserts.
  assign bus.rf_we_o     = rst_i && we;
  assign bus.rf_addr_o   = wr_addr;
  assign bus.rf_data_o   = wr_data;
  assign bus.mdu_ready_o = rst_i && ready;
  assign bus.pending_o   = rst_i && fifo_match;
  assign bus.stall_o     = stall_q;
endmodule
